// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode hazard controller: stall vector layout,
// stall encodings and controller states.
package hazard_ctrl_pkg;

    localparam int STALL_VEC_W  = 6;
    localparam int STALL_BIT_PC = 0;
    localparam int STALL_BIT_IF = 1;
    localparam int STALL_BIT_ID = 2;
    localparam int STALL_BIT_EX = 3;
    localparam int STALL_BIT_MEM = 4;
    localparam int STALL_BIT_WB = 5;

    localparam logic [STALL_VEC_W-1:0] STALL_NONE = '0;
    // 6'b000111: hold pc/if/id while execute drains
    localparam logic [STALL_VEC_W-1:0] STALL_HAZARD =
        (6'd1 << STALL_BIT_PC) | (6'd1 << STALL_BIT_IF) | (6'd1 << STALL_BIT_ID);
    // 6'b001111: also freeze execute during a multi-cycle op
    localparam logic [STALL_VEC_W-1:0] STALL_EXBUSY = STALL_HAZARD | (6'd1 << STALL_BIT_EX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    function automatic logic [31:0] reg_mask(input logic en, input logic [4:0] addr);
        return en ? (32'd1 << addr) : 32'd0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, x0 never busy.
// Writeback clears are visible to the same-cycle lookups (regfile write-through).
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en_i,
    input  logic [4:0] set_addr_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_addr_i,
    input  logic       rd1_en_i,
    input  logic [4:0] rd1_addr_i,
    input  logic       rd2_en_i,
    input  logic [4:0] rd2_addr_i,
    input  logic       waw_en_i,
    input  logic [4:0] waw_addr_i,
    output logic       rd1_busy_o,
    output logic       rd2_busy_o,
    output logic       waw_busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] busy_eff;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign set_mask = reg_mask(set_en_i, set_addr_i);
    assign clr_mask = reg_mask(clr_en_i, clr_addr_i);
    assign busy_eff = busy_q & ~clr_mask;
    // Set applied after clear so a same-register issue and retire leaves it busy.
    assign busy_d   = (busy_eff | set_mask) & ~32'd1;

    assign rd1_busy_o = rd1_en_i & busy_eff[rd1_addr_i];
    assign rd2_busy_o = rd2_en_i & busy_eff[rd2_addr_i];
    assign waw_busy_o = waw_en_i & busy_eff[waw_addr_i];

    // NOTE: the busy bits are reset explicitly; a stale busy bit after reset
    // would stall decode forever. Non-blocking assignment for all registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW/WAW detection, stall/flush/issue control,
// stall statistics and a hazard-stall watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 255,
    parameter int STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    input  logic               id_reg1_read_i,
    input  logic               id_reg2_read_i,
    input  logic [4:0]         id_reg1_addr_i,
    input  logic [4:0]         id_reg2_addr_i,
    input  logic               id_wreg_i,
    input  logic [4:0]         id_wd_i,
    input  logic               wb_we_i,
    input  logic [4:0]         wb_addr_i,
    input  logic               ex_stallreq_i,
    input  logic               branch_taken_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               issue_o,
    output logic [31:0]        stall_cnt_o,
    output logic               deadlock_o
);

    localparam int RUN_W = $clog2(WDOG_LIMIT + 1);

    hz_state_e        state_q, state_d;
    logic [31:0]      stall_cnt_q;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             deadlock_q;

    logic raw1, raw2, waw, hazard;
    logic blocked, hazard_stall, sb_set_en;

    assign sb_set_en = issue_o & id_wreg_i & (id_wd_i != 5'd0);

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set_en),
        .set_addr_i (id_wd_i),
        .clr_en_i   (wb_we_i),
        .clr_addr_i (wb_addr_i),
        .rd1_en_i   (id_reg1_read_i),
        .rd1_addr_i (id_reg1_addr_i),
        .rd2_en_i   (id_reg2_read_i),
        .rd2_addr_i (id_reg2_addr_i),
        .waw_en_i   (id_wreg_i),
        .waw_addr_i (id_wd_i),
        .rd1_busy_o (raw1),
        .rd2_busy_o (raw2),
        .waw_busy_o (waw)
    );

    assign hazard  = raw1 | raw2 | waw;
    // Nothing stalls or issues in reset, on a taken branch, or while flushing.
    assign blocked = rst | branch_taken_i | (state_q == ST_FLUSH);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        stall_o      = '0;
        issue_o      = 1'b0;
        hazard_stall = 1'b0;
        state_d      = state_q;
        run_cnt_d    = '0;

        if (!blocked) begin
            if (ex_stallreq_i) begin
                stall_o = STALL_W'(STALL_EXBUSY);
            end else if (id_valid_i && hazard) begin
                stall_o = STALL_W'(STALL_HAZARD);
            end
            issue_o      = id_valid_i & ~hazard & ~ex_stallreq_i;
            hazard_stall = id_valid_i & hazard;
        end

        if (hazard_stall) begin
            run_cnt_d = (run_cnt_q == RUN_W'(WDOG_LIMIT)) ? run_cnt_q : run_cnt_q + 1'b1;
        end

        case (state_q)
            ST_RUN, ST_STALL: begin
                if (branch_taken_i) begin
                    state_d = ST_FLUSH;
                end else if (id_valid_i && (hazard || ex_stallreq_i)) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = branch_taken_i ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            run_cnt_q   <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            if ((stall_o != '0) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (run_cnt_d == RUN_W'(WDOG_LIMIT)) begin
                deadlock_q <= 1'b1;
            end
        end
    end

    assign flush_o     = (state_q == ST_FLUSH) & ~rst;
    assign stall_cnt_o = stall_cnt_q;
    assign deadlock_o  = deadlock_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: randomized traffic against a behavioural
// model, plus directed sequences with literal expectations.
module tb_hazard_ctrl;

    localparam int LIMIT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wreg_i;
    logic [4:0]  id_reg1_addr_i, id_reg2_addr_i, id_wd_i, wb_addr_i;
    logic        wb_we_i, ex_stallreq_i, branch_taken_i;
    logic [5:0]  stall_o;
    logic        flush_o, issue_o, deadlock_o;
    logic [31:0] stall_cnt_o;

    always #5 clk = ~clk;

    hazard_ctrl #(.WDOG_LIMIT(LIMIT), .STALL_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_wreg_i      (id_wreg_i),
        .id_wd_i        (id_wd_i),
        .wb_we_i        (wb_we_i),
        .wb_addr_i      (wb_addr_i),
        .ex_stallreq_i  (ex_stallreq_i),
        .branch_taken_i (branch_taken_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .issue_o        (issue_o),
        .stall_cnt_o    (stall_cnt_o),
        .deadlock_o     (deadlock_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: set of busy registers, a pending-flush flag, counters.
    bit          started = 1'b0;
    bit [31:0]   m_busy, n_busy;
    bit          m_flush, n_flush;
    bit [31:0]   m_scnt, n_scnt;
    int          m_run, n_run;
    bit          m_dead, n_dead;

    always @(negedge clk) begin
        bit [31:0] visible;
        bit        haz, blk, e_issue, e_flush;
        bit [5:0]  e_stall;

        visible = m_busy;
        if (wb_we_i) visible[wb_addr_i] = 1'b0;
        haz = (id_reg1_read_i && id_reg1_addr_i != 0 && visible[id_reg1_addr_i]) ||
              (id_reg2_read_i && id_reg2_addr_i != 0 && visible[id_reg2_addr_i]) ||
              (id_wreg_i && id_wd_i != 0 && visible[id_wd_i]);
        blk = rst || branch_taken_i || m_flush;
        if (blk)                    e_stall = 6'b000000;
        else if (ex_stallreq_i)     e_stall = 6'b001111;
        else if (id_valid_i && haz) e_stall = 6'b000111;
        else                        e_stall = 6'b000000;
        e_issue = !blk && id_valid_i && !haz && !ex_stallreq_i;
        e_flush = m_flush && !rst;

        if (started) begin
            check("model stall_o",     {26'd0, stall_o}, {26'd0, e_stall});
            check("model issue_o",     {31'd0, issue_o}, {31'd0, e_issue});
            check("model flush_o",     {31'd0, flush_o}, {31'd0, e_flush});
            check("model stall_cnt_o", stall_cnt_o, m_scnt);
            check("model deadlock_o",  {31'd0, deadlock_o}, {31'd0, m_dead});
        end

        if (rst) begin
            n_busy = '0; n_flush = 1'b0; n_scnt = '0; n_run = 0; n_dead = 1'b0;
        end else begin
            n_busy = visible;
            if (e_issue && id_wreg_i && id_wd_i != 0) n_busy[id_wd_i] = 1'b1;
            n_busy[0] = 1'b0;
            n_flush = branch_taken_i;
            n_scnt  = (e_stall != 0 && m_scnt != 32'hFFFF_FFFF) ? m_scnt + 1 : m_scnt;
            n_run   = (!blk && id_valid_i && haz) ? ((m_run < LIMIT) ? m_run + 1 : m_run) : 0;
            n_dead  = m_dead || (n_run >= LIMIT);
        end
    end

    always @(posedge clk) begin
        if (rst) started <= 1'b1;
        m_busy  <= n_busy;
        m_flush <= n_flush;
        m_scnt  <= n_scnt;
        m_run   <= n_run;
        m_dead  <= n_dead;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 0; id_reg1_read_i = 0; id_reg2_read_i = 0; id_wreg_i = 0;
        id_reg1_addr_i = 0; id_reg2_addr_i = 0; id_wd_i = 0;
        wb_we_i = 0; wb_addr_i = 0; ex_stallreq_i = 0; branch_taken_i = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic write_to(input logic [4:0] rd);
        idle(); id_valid_i = 1; id_wreg_i = 1; id_wd_i = rd;
    endtask

    task automatic read_of(input logic [4:0] rs);
        idle(); id_valid_i = 1; id_reg1_read_i = 1; id_reg1_addr_i = rs;
    endtask

    initial begin
        idle();
        rst = 1; tick(); tick();
        rst = 0;
        @(negedge clk);
        check("reset stall_o", {26'd0, stall_o}, 32'd0);
        check("reset flush_o", {31'd0, flush_o}, 32'd0);
        check("reset stall_cnt_o", stall_cnt_o, 32'd0);
        check("reset deadlock_o", {31'd0, deadlock_o}, 32'd0);
        tick();

        // RAW on x5 until writeback retires it
        write_to(5); @(negedge clk); check("x5 write issue", {31'd0, issue_o}, 32'd1); tick();
        for (int i = 0; i < 2; i++) begin
            read_of(5); @(negedge clk);
            check("x5 raw stall", {26'd0, stall_o}, 32'h07);
            check("x5 raw no issue", {31'd0, issue_o}, 32'd0);
            tick();
        end
        read_of(5); wb_we_i = 1; wb_addr_i = 5; @(negedge clk);
        check("x5 wb issue", {31'd0, issue_o}, 32'd1);
        check("x5 wb no stall", {26'd0, stall_o}, 32'd0);
        tick();
        idle(); @(negedge clk); check("stall_cnt after raw", stall_cnt_o, 32'd2); tick();

        // x0 reads never hazard
        write_to(9); tick();
        idle(); id_valid_i = 1; id_reg1_read_i = 1; id_reg2_read_i = 1; @(negedge clk);
        check("x0 read issue", {31'd0, issue_o}, 32'd1);
        check("x0 read no stall", {26'd0, stall_o}, 32'd0);
        tick();

        // Execute busy with a hazard present
        for (int i = 0; i < 3; i++) begin
            read_of(9); ex_stallreq_i = 1; @(negedge clk);
            check("ex busy stall", {26'd0, stall_o}, 32'h0F);
            tick();
        end
        idle(); @(negedge clk); check("stall_cnt after ex", stall_cnt_o, 32'd5); tick();

        // Taken branch during a RAW stall
        read_of(9); @(negedge clk); check("pre-branch stall", {26'd0, stall_o}, 32'h07); tick();
        read_of(9); branch_taken_i = 1; @(negedge clk);
        check("branch stall", {26'd0, stall_o}, 32'd0);
        check("branch issue", {31'd0, issue_o}, 32'd0);
        check("branch flush", {31'd0, flush_o}, 32'd0);
        tick();
        read_of(9); @(negedge clk);
        check("flush cycle flush", {31'd0, flush_o}, 32'd1);
        check("flush cycle issue", {31'd0, issue_o}, 32'd0);
        check("flush cycle stall", {26'd0, stall_o}, 32'd0);
        tick();
        read_of(9); @(negedge clk);
        check("post flush flush", {31'd0, flush_o}, 32'd0);
        check("post flush busy kept", {26'd0, stall_o}, 32'h07);
        tick();
        idle(); wb_we_i = 1; wb_addr_i = 9; tick();

        // Same-cycle issue and retire of x7: set wins
        write_to(7); wb_we_i = 1; wb_addr_i = 7; @(negedge clk);
        check("x7 issue", {31'd0, issue_o}, 32'd1); tick();
        read_of(7); @(negedge clk); check("x7 still busy", {26'd0, stall_o}, 32'h07); tick();
        idle(); wb_we_i = 1; wb_addr_i = 7; tick();

        // Reset right after a taken branch leaves no flush pulse
        idle(); branch_taken_i = 1; tick();
        idle(); rst = 1; @(negedge clk); check("rst mid flush", {31'd0, flush_o}, 32'd0); tick();
        rst = 0; @(negedge clk); check("after rst flush", {31'd0, flush_o}, 32'd0); tick();

        // Watchdog
        do_reset();
        write_to(3); tick();
        for (int i = 1; i <= LIMIT; i++) begin
            read_of(3);
            if (i == LIMIT) begin
                @(negedge clk);
                check("wdog not yet", {31'd0, deadlock_o}, 32'd0);
            end
            tick();
        end
        idle(); wb_we_i = 1; wb_addr_i = 3; @(negedge clk);
        check("wdog set", {31'd0, deadlock_o}, 32'd1); tick();
        idle(); @(negedge clk); check("wdog sticky", {31'd0, deadlock_o}, 32'd1); tick();
        do_reset(); @(negedge clk); check("wdog cleared", {31'd0, deadlock_o}, 32'd0); tick();

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            id_valid_i     = ($urandom_range(0, 3) != 0);
            id_reg1_read_i = $urandom_range(0, 1);
            id_reg2_read_i = $urandom_range(0, 1);
            id_reg1_addr_i = 5'($urandom_range(0, 7));
            id_reg2_addr_i = 5'($urandom_range(0, 7));
            id_wreg_i      = $urandom_range(0, 1);
            id_wd_i        = 5'($urandom_range(0, 7));
            wb_we_i        = ($urandom_range(0, 2) == 0);
            wb_addr_i      = 5'($urandom_range(0, 7));
            ex_stallreq_i  = ($urandom_range(0, 7) == 0);
            branch_taken_i = ($urandom_range(0, 19) == 0);
            tick();
        end
        do_reset(); idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
